// File: rtl/alu_wb_stage_if.sv
// Bus between the ALU/issue side and the writeback stage: result input,
// register-file write port, status-register outputs and hazard query.
interface alu_wb_stage_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 6
);
    logic              inValid;
    logic              inReady;
    logic [3:0]        inOp;
    logic [IDX_W-1:0]  inRd;
    logic [DATA_W-1:0] inDst;
    logic [3:0]        inSr;
    logic              wbStall;
    logic              regWrEn;
    logic [IDX_W-1:0]  regWrIdx;
    logic [DATA_W-1:0] regWrData;
    logic [3:0]        srCommit;
    logic [3:0]        srFwd;
    logic [IDX_W-1:0]  queryIdx;
    logic              queryHit;
    logic [1:0]        count;

    modport master (
        output inValid, inOp, inRd, inDst, inSr, wbStall, queryIdx,
        input  inReady, regWrEn, regWrIdx, regWrData, srCommit, srFwd,
               queryHit, count
    );

    modport slave (
        input  inValid, inOp, inRd, inDst, inSr, wbStall, queryIdx,
        output inReady, regWrEn, regWrIdx, regWrData, srCommit, srFwd,
               queryHit, count
    );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry result buffer draining into the register-file
// write port, architectural SR, forwarded SR and pending-write hazard flag.
module alu_wb_stage #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 6
) (
    input  logic          clk,
    input  logic          reset,
    alu_wb_stage_if.slave bus
);
    typedef struct packed {
        logic [3:0]        op;
        logic [IDX_W-1:0]  rd;
        logic [DATA_W-1:0] dst;
        logic [3:0]        sr;
    } entry_t;

    entry_t     mem_q [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [3:0] sr_q, sr_d;

    logic       push, pop;
    entry_t     head_e;
    logic [1:0] ent_vld;
    logic       yng;

    // Ops 1..A write a register; B..F only touch SR; 0 is a bubble.
    function automatic logic is_reg_write(input logic [3:0] op);
        return (op != 4'h0) && (op <= 4'hA);
    endfunction

    always_comb begin
        push    = bus.inValid && (count_q != 2'd2);
        pop     = (count_q != 2'd0) && !bus.wbStall;
        head_e  = mem_q[head_q];
        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (pop && !push)
            count_d = count_q - 2'd1;
        sr_d = sr_q;
        if (pop && (head_e.op != 4'h0))
            sr_d = head_e.sr;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            sr_q    <= 4'h0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sr_q    <= sr_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count_q alone marks entries valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[tail_q] <= '{op: bus.inOp, rd: bus.inRd, dst: bus.inDst, sr: bus.inSr};
    end

    always_comb begin
        ent_vld = 2'b00;
        if (count_q == 2'd2)
            ent_vld = 2'b11;
        else if (count_q == 2'd1)
            ent_vld = 2'b01 << head_q;
        yng = ~tail_q;

        bus.inReady   = (count_q != 2'd2);
        bus.count     = count_q;
        bus.srCommit  = sr_q;
        bus.regWrEn   = pop && is_reg_write(head_e.op);
        bus.regWrIdx  = (count_q != 2'd0) ? head_e.rd  : '0;
        bus.regWrData = (count_q != 2'd0) ? head_e.dst : '0;

        // The older entry is considered first so the youngest non-bubble wins.
        bus.srFwd = sr_q;
        if (ent_vld[head_q] && (mem_q[head_q].op != 4'h0))
            bus.srFwd = mem_q[head_q].sr;
        if ((count_q == 2'd2) && (mem_q[yng].op != 4'h0))
            bus.srFwd = mem_q[yng].sr;

        bus.queryHit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ent_vld[i] && is_reg_write(mem_q[i].op) && (mem_q[i].rd == bus.queryIdx))
                bus.queryHit = 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed vector table, stall/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_alu_wb_stage;
    localparam int DW = 64;
    localparam int IW = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_wb_stage_if #(.DATA_W(DW), .IDX_W(IW)) bus ();
    alu_wb_stage #(.DATA_W(DW), .IDX_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]    op;
        logic [IW-1:0] rd;
        logic [DW-1:0] dst;
        logic [3:0]    sr;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] m_sr = 4'h0;

    logic          cur_v  = 1'b0;
    logic [3:0]    cur_op = 4'h0;
    logic [IW-1:0] cur_rd = '0;
    logic [DW-1:0] cur_dst = '0;
    logic [3:0]    cur_sr = 4'h0;
    logic          cur_st = 1'b0;
    logic [IW-1:0] cur_qi = '0;

    typedef struct {
        logic          v;
        logic [3:0]    op;
        logic [IW-1:0] rd;
        logic [DW-1:0] dst;
        logic [3:0]    sr;
        logic          st;
        logic [IW-1:0] qi;
        logic          e_rdy;
        logic          e_wen;
        logic [IW-1:0] e_idx;
        logic [DW-1:0] e_data;
        logic [1:0]    e_cnt;
        logic [3:0]    e_src;
        logic [3:0]    e_srf;
        logic          e_hit;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [IW-1:0] rd,
                         input logic [DW-1:0] dst, input logic [3:0] sr,
                         input logic st, input logic [IW-1:0] qi);
        @(negedge clk);
        cur_v = v; cur_op = op; cur_rd = rd; cur_dst = dst; cur_sr = sr; cur_st = st; cur_qi = qi;
        bus.inValid = v; bus.inOp = op; bus.inRd = rd; bus.inDst = dst; bus.inSr = sr;
        bus.wbStall = st; bus.queryIdx = qi;
        #1;
    endtask

    function automatic logic writes_reg(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'hA);
    endfunction

    task automatic model_check(input string tag);
        logic [3:0]    fwd;
        logic          hit;
        logic          wen;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        fwd = m_sr;
        hit = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].op != 4'h0) fwd = mq[i].sr;
            if (writes_reg(mq[i].op) && (mq[i].rd == cur_qi)) hit = 1'b1;
        end
        wen  = (mq.size() > 0) && !cur_st && writes_reg(mq[0].op);
        idx  = (mq.size() > 0) ? mq[0].rd  : '0;
        data = (mq.size() > 0) ? mq[0].dst : '0;
        check({tag, ".inReady"},   64'(bus.inReady),   64'(mq.size() != 2));
        check({tag, ".regWrEn"},   64'(bus.regWrEn),   64'(wen));
        check({tag, ".regWrIdx"},  64'(bus.regWrIdx),  64'(idx));
        check({tag, ".regWrData"}, bus.regWrData,      data);
        check({tag, ".count"},     64'(bus.count),     64'(mq.size()));
        check({tag, ".srCommit"},  64'(bus.srCommit),  64'(m_sr));
        check({tag, ".srFwd"},     64'(bus.srFwd),     64'(fwd));
        check({tag, ".queryHit"},  64'(bus.queryHit),  64'(hit));
    endtask

    task automatic advance();
        logic push, pop;
        ent_t e;
        push = cur_v && (mq.size() != 2);
        pop  = (mq.size() > 0) && !cur_st;
        @(posedge clk);
        if (pop) begin
            e = mq.pop_front();
            if (e.op != 4'h0) m_sr = e.sr;
        end
        if (push) mq.push_back('{op: cur_op, rd: cur_rd, dst: cur_dst, sr: cur_sr});
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] op,
                        input logic [IW-1:0] rd, input logic [DW-1:0] dst,
                        input logic [3:0] sr, input logic st, input logic [IW-1:0] qi);
        drive(v, op, rd, dst, sr, st, qi);
        model_check(tag);
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_sr = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'h1, 6'd5, 64'h1234, 4'h3, 1'b0, 6'd5,  1'b1, 1'b0, 6'd0, 64'h0,    2'd0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b0, 6'd5,  1'b1, 1'b1, 6'd5, 64'h1234, 2'd1, 4'h0, 4'h3, 1'b1};
        vecs[2]  = '{1'b1, 4'hB, 6'd7, 64'hAA,   4'h2, 1'b0, 6'd7,  1'b1, 1'b0, 6'd0, 64'h0,    2'd0, 4'h3, 4'h3, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b1, 6'd7,  1'b1, 1'b0, 6'd7, 64'hAA,   2'd1, 4'h3, 4'h2, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b0, 6'd7,  1'b1, 1'b0, 6'd7, 64'hAA,   2'd1, 4'h3, 4'h2, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 6'd9, 64'h55,   4'hF, 1'b1, 6'd9,  1'b1, 1'b0, 6'd0, 64'h0,    2'd0, 4'h2, 4'h2, 1'b0};
        vecs[6]  = '{1'b1, 4'h1, 6'd9, 64'h99,   4'h4, 1'b1, 6'd9,  1'b1, 1'b0, 6'd9, 64'h55,   2'd1, 4'h2, 4'h2, 1'b0};
        vecs[7]  = '{1'b1, 4'h2, 6'd3, 64'h33,   4'h6, 1'b1, 6'd9,  1'b0, 1'b0, 6'd9, 64'h55,   2'd2, 4'h2, 4'h4, 1'b1};
        vecs[8]  = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b1, 6'd10, 1'b0, 1'b0, 6'd9, 64'h55,   2'd2, 4'h2, 4'h4, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b0, 6'd9,  1'b0, 1'b0, 6'd9, 64'h55,   2'd2, 4'h2, 4'h4, 1'b1};
        vecs[10] = '{1'b1, 4'h3, 6'd4, 64'h44,   4'h8, 1'b0, 6'd4,  1'b1, 1'b1, 6'd9, 64'h99,   2'd1, 4'h2, 4'h4, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b0, 6'd4,  1'b1, 1'b1, 6'd4, 64'h44,   2'd1, 4'h4, 4'h8, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 6'd0, 64'h0,    4'h0, 1'b0, 6'd4,  1'b1, 1'b0, 6'd0, 64'h0,    2'd0, 4'h8, 4'h8, 1'b0};

        bus.inValid = 1'b0; bus.inOp = 4'h0; bus.inRd = '0; bus.inDst = '0;
        bus.inSr = 4'h0; bus.wbStall = 1'b0; bus.queryIdx = '0;

        // Reset state, observed while reset is still asserted.
        #1;
        check("rst.inReady",   64'(bus.inReady),  64'd1);
        check("rst.regWrEn",   64'(bus.regWrEn),  64'd0);
        check("rst.regWrData", bus.regWrData,     64'd0);
        check("rst.srFwd",     64'(bus.srFwd),    64'd0);
        check("rst.count",     64'(bus.count),    64'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].dst, vecs[i].sr, vecs[i].st, vecs[i].qi);
            check($sformatf("vec%0d.inReady", i),   64'(bus.inReady),  64'(vecs[i].e_rdy));
            check($sformatf("vec%0d.regWrEn", i),   64'(bus.regWrEn),  64'(vecs[i].e_wen));
            check($sformatf("vec%0d.regWrIdx", i),  64'(bus.regWrIdx), 64'(vecs[i].e_idx));
            check($sformatf("vec%0d.regWrData", i), bus.regWrData,     vecs[i].e_data);
            check($sformatf("vec%0d.count", i),     64'(bus.count),    64'(vecs[i].e_cnt));
            check($sformatf("vec%0d.srCommit", i),  64'(bus.srCommit), 64'(vecs[i].e_src));
            check($sformatf("vec%0d.srFwd", i),     64'(bus.srFwd),    64'(vecs[i].e_srf));
            check($sformatf("vec%0d.queryHit", i),  64'(bus.queryHit), 64'(vecs[i].e_hit));
            advance();
        end

        // Three back-to-back pushes under stall, then release.
        step("stall0", 1'b1, 4'h1, 6'd11, 64'hA1, 4'h1, 1'b1, 6'd11);
        step("stall1", 1'b1, 4'h5, 6'd12, 64'hA2, 4'h5, 1'b1, 6'd12);
        step("stall2", 1'b1, 4'h7, 6'd13, 64'hA3, 4'h7, 1'b1, 6'd13);
        drive(1'b0, 4'h0, '0, '0, 4'h0, 1'b1, 6'd13);
        check("stall.full.count",   64'(bus.count),   64'd2);
        check("stall.full.inReady", 64'(bus.inReady), 64'd0);
        check("stall.full.hit13",   64'(bus.queryHit), 64'd0);
        advance();
        for (int i = 0; i < 4; i++)
            step($sformatf("drain%0d", i), 1'b0, 4'h0, '0, '0, 4'h0, 1'b0, 6'd12);

        // Asynchronous reset with the buffer full.
        step("prerst0", 1'b1, 4'h2, 6'd20, 64'hB1, 4'h9, 1'b1, 6'd20);
        step("prerst1", 1'b1, 4'h3, 6'd21, 64'hB2, 4'hA, 1'b1, 6'd20);
        drive(1'b0, 4'h0, '0, '0, 4'h0, 1'b0, 6'd20);
        #2 reset = 1'b0;
        #1;
        check("midrst.regWrEn",  64'(bus.regWrEn),  64'd0);
        check("midrst.count",    64'(bus.count),    64'd0);
        check("midrst.srCommit", 64'(bus.srCommit), 64'd0);
        check("midrst.srFwd",    64'(bus.srFwd),    64'd0);
        check("midrst.queryHit", 64'(bus.queryHit), 64'd0);
        check("midrst.inReady",  64'(bus.inReady),  64'd1);
        mq.delete();
        m_sr = 4'h0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            step($sformatf("postrst%0d", i), 1'b0, 4'h0, '0, '0, 4'h0, 1'b0, 6'd20);
        step("firstpush", 1'b1, 4'h4, 6'd22, 64'hC1, 4'hC, 1'b0, 6'd22);
        step("firstpush.wb", 1'b0, 4'h0, '0, '0, 4'h0, 1'b0, 6'd22);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)),
                 IW'($urandom_range(0, 7)),
                 {$urandom, $urandom},
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0,
                 IW'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the 64-bit arithmetic ALU. Captures each ALU result (`dst`, `sro`) with its opcode and destination register index into a 2-entry buffer. Drains the buffer into the register-file write port, stalling when that port is busy, and holds the architectural status register (SR). Also supplies the forwarded SR for the ALU's `sri` input and a pending-write hazard flag for the issue logic.

## Interface
Parameters:
- DATA_W, 64, result/register width
- IDX_W, 6, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- inValid  in  1  ALU result valid
- inReady  out  1  stage can accept; equals (count != 2)
- inOp  in  4  opMode that produced the result
- inRd  in  IDX_W  destination register index
- inDst  in  DATA_W  ALU `dst`
- inSr  in  4  ALU `sro`
- wbStall  in  1  register-file write port busy this cycle
- regWrEn  out  1  register write strobe
- regWrIdx  out  IDX_W  register write index
- regWrData  out  DATA_W  register write data
- srCommit  out  4  architectural SR
- srFwd  out  4  youngest SR, pending or committed; drives ALU `sri`
- queryIdx  in  IDX_W  index probed by issue logic
- queryHit  out  1  a buffered entry will write queryIdx
- count  out  2  entries held (0..2)

## Operation
- Storage: 2-entry FIFO with head pointer, tail pointer and 2-bit count. Each entry holds {op, rd, dst, sr}.
- Push: occurs when inValid && inReady. When count==2, inReady is low and the input is ignored, even if a pop happens in the same cycle.
- Pop: occurs when count>0 && !wbStall. Head entry leaves at the clock edge.
- Op classes, applied to the head entry:
  - 4'h0 NONE: bubble. Pops without a register write or SR change.
  - 4'h1-4'hA (ADD..ADDC): register write; SR updated to the entry's sr.
  - 4'hB-4'hF (CMPxx): SR-only. No register write; SR updated to the entry's sr.
- regWrEn = (count>0) && !wbStall && head op in 1..A. regWrIdx and regWrData always reflect the head entry, or 0 when the buffer is empty.
- srCommit loads the head sr on the pop edge for classes 1..F.
- srFwd selection:
  - sr of the youngest buffered entry with op != 0, if any;
  - otherwise srCommit.
  - Combinational from stored state only; inSr is never bypassed.
- queryHit is high when any valid entry has op in 1..A and rd == queryIdx. Combinational; the current input is not considered.
- Push and pop in the same cycle with count==1: head advances, new entry written at tail, count stays 1.
- Pointers are 1 bit and wrap 1→0.

## Timing
- Reset asserted (async): count=0, head/tail=0, srCommit=4'h0, entries invalid. Resulting outputs: inReady=1, regWrEn=0, regWrIdx=0, regWrData=0, srFwd=4'h0, queryHit=0.
- Reset mid-operation discards buffered entries with no write. Deassertion is sampled synchronously; the first push is accepted on the first rising edge after deassertion.
- Latency: result pushed at edge N appears on regWrEn/Idx/Data during cycle N+1 if wbStall=0. srCommit updates at edge N+1.
- Throughput: 1 result/cycle sustained while wbStall=0.
- wbStall holds the head stable: regWrEn=0, data unchanged, no pop. Up to 1 further push is accepted before inReady drops.
- inReady, regWrEn, srFwd and queryHit are combinational from registers and wbStall/queryIdx. There is no combinational path from inValid to inReady.

## Test plan
- Single ADD (op 1, rd 5, dst 64'h1234, sr 4'h3), wbStall=0 → next cycle regWrEn=1, regWrIdx=5, regWrData=64'h1234. After that edge srCommit=4'h3 and count=0.
- CMPEQ (op B, rd 7, sr 4'h2) → regWrEn never asserts. srFwd=4'h2 while buffered; srCommit=4'h2 after pop.
- Hold wbStall=1 and push 3 back-to-back results → first two accepted, count=2, inReady=0, third held. Release stall → writes in order with no loss or duplication.
- With count==1, push and pop in the same cycle → count stays 1, data order preserved across pointer wrap.
- Push op 1 rd 9 with stall, queryIdx=9 → queryHit=1. queryIdx=10 → 0. A buffered op 0 with rd 9 → queryHit=0.
- Assert reset with count=2 → regWrEn=0 immediately, count=0, srCommit=0, no writes after release.
